// File: rtl/i2c_target_regs.sv
// I2C target with a 4-entry x 8-bit register bank and a local access port.
// SCL/SDA are oversampled on clk_i; all bus events are derived from synchronized copies.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [1:0] loc_addr_i,
    input  logic       loc_we_i,
    input  logic [7:0] loc_wdata_i,
    output logic [7:0] loc_rdata_o,
    output logic       wr_done_o,
    output logic       rd_done_o,
    output logic [2:0] nby_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c, wr_store;

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic       rw_q, nack_q, sda_oe_q, busy_q, wr_done_q, rd_done_q;
    logic [2:0] nby_q;
    logic [7:0] bank_q [4];

    // Synchronizers preset to 1 so an idle (pulled-up) bus produces no edges out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign start_c  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_c   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign wr_store = (state_q == WR_BYTE) && scl_fall && (bit_cnt_q == 4'd8) &&
                      !idx_q[2] && !start_c && !stop_c;

    // The I2C store is assigned last so it overrides a colliding local write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) bank_q[i] <= 8'h00;
        end else begin
            if (loc_we_i) bank_q[loc_addr_i] <= loc_wdata_i;
            if (wr_store) bank_q[idx_q[1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            idx_q     <= 3'd0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            nby_q     <= 3'd0;
        end else begin
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            if (start_c || stop_c) begin
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                if (busy_q && !rw_q && (idx_q != 3'd0)) begin
                    nby_q     <= idx_q;
                    wr_done_q <= 1'b1;
                end
                bit_cnt_q <= 4'd0;
                idx_q     <= 3'd0;
                state_q   <= start_c ? ADDR : IDLE;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                            bit_cnt_q <= 4'd0;
                            rw_q      <= shift_q[0];
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= ADDR_ACK;
                            end else begin
                                state_q  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                shift_q   <= bank_q[0];
                                sda_oe_q  <= ~bank_q[0][7];
                                bit_cnt_q <= 4'd1;
                                state_q   <= RD_BYTE;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= WR_ACK;
                            if (!idx_q[2]) begin
                                idx_q    <= idx_q + 3'd1;
                                sda_oe_q <= 1'b1;
                                nack_q   <= 1'b0;
                            end else begin
                                sda_oe_q <= 1'b0;
                                nack_q   <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= nack_q ? IGNORE : WR_BYTE;
                        end
                    end
                    // bit_cnt_q counts bits already placed on the bus in this byte.
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= RD_ACK;
                            end else begin
                                sda_oe_q  <= ~shift_q[6];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                rd_done_q <= 1'b1;
                                state_q   <= IGNORE;
                            end else begin
                                idx_q <= {1'b0, idx_q[1:0] + 2'd1};
                            end
                        end else if (scl_fall) begin
                            shift_q   <= bank_q[idx_q[1:0]];
                            sda_oe_q  <= ~bank_q[idx_q[1:0]][7];
                            bit_cnt_q <= 4'd1;
                            state_q   <= RD_BYTE;
                        end
                    end
                    IGNORE:  sda_oe_q <= 1'b0;
                    default: state_q  <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign busy_o      = busy_q;
    assign wr_done_o   = wr_done_q;
    assign rd_done_o   = rd_done_q;
    assign nby_o       = nby_q;
    assign loc_rdata_o = bank_q[loc_addr_i];

endmodule
